bram_serial_slave: RTL

//  Serial-bus slave front end for the single-port BRAM (clk, wr, address, data, q).

---
 rtl/bram_serial_pkg.sv | 32 +++
 rtl/ser_shift_reg.sv | 40 ++++
 rtl/bram_serial_slave.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_serial_pkg.sv
// Shared types and frame constants for the serial BRAM slave.
// Optional even-parity framing is enabled by defining SLAVE_PARITY_EN.
package bram_serial_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      LEN,
      WDATA,
      RFETCH,
      RSTART,
      RDATA
   } state_t;

   localparam int DEF_DEPTH  = 4096;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_LEN_W  = 8;

   localparam int START_BITS = 1;
   localparam int CMD_BITS   = 1;

   localparam logic CMD_WRITE = 1'b1;
   localparam logic CMD_READ  = 1'b0;

`ifdef SLAVE_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

endpackage

// File: rtl/ser_shift_reg.sv
// MSB-first shift register with parallel load, serial in/out
// and a bit counter that restarts on load or clear.
module ser_shift_reg #(
   parameter int W  = 16,
   parameter int CW = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rstN,
   input  logic          load,
   input  logic [W-1:0]  din,
   input  logic          shift,
   input  logic          clr,
   input  logic          sin,
   output logic [W-1:0]  nxt,
   output logic          sout,
   output logic [CW-1:0] cnt
);

   logic [W-1:0] q;

   assign nxt  = {q[W-2:0], sin};
   assign sout = q[W-1];

   always_ff @(posedge clk) begin
      if (!rstN) begin
         q   <= '0;
         cnt <= '0;
      end else begin
         if (load)
            q <= din;
         else if (shift)
            q <= nxt;
         if (load || clr)
            cnt <= '0;
         else if (shift)
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/bram_serial_slave.sv
// Serial request slave driving a single-port BRAM.
// SLAVE_PARITY_EN adds an even-parity bit to every data word.
module bram_serial_slave
   import bram_serial_pkg::*;
#(
   parameter int MEMORY_DEPTH = DEF_DEPTH,
   parameter int DATA_WIDTH   = DEF_DATA_W,
   parameter int LEN_WIDTH    = DEF_LEN_W,
   localparam int ADDR_W      = $clog2(MEMORY_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  rx,
   output logic                  tx,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_wr,
   input  logic [DATA_WIDTH-1:0] mem_q
);

   localparam int WB   = DATA_WIDTH + PAR_BITS;
   localparam int FB   = START_BITS + WB;
   localparam int RX_A = (ADDR_W > LEN_WIDTH) ? ADDR_W : LEN_WIDTH;
   localparam int RX_W = (WB > RX_A) ? WB : RX_A;
   localparam int RCW  = $clog2(RX_W + 1);
   localparam int TCW  = $clog2(FB + 1);

   state_t state, state_n;

   logic                  rx_shift, rx_clr;
   logic [RX_W-1:0]       rx_nxt;
   logic                  rx_sout;
   logic [RCW-1:0]        rx_cnt;
   logic                  tx_load, tx_shift;
   logic [FB-1:0]         tx_frame;
   logic [FB-1:0]         tx_nxt;
   logic                  tx_sout;
   logic [TCW-1:0]        tx_cnt;
   logic                  tx_act;

   logic                  start_acc, addr_end, len_end;
   logic                  word_end, tx_word_end;
   logic                  cmd_r;
   logic [ADDR_W-1:0]     base, cur;
   logic [LEN_WIDTH-1:0]  rem;
   logic [LEN_WIDTH-1:0]  len_val;
   logic [WB-1:0]         word_val;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  par_ok;

   function automatic logic [ADDR_W-1:0] inc(
      input logic [ADDR_W-1:0] a
   );
      return (a == ADDR_W'(MEMORY_DEPTH - 1)) ? '0 : a + 1'b1;
   endfunction

   ser_shift_reg #(.W(RX_W)) u_rx (
      .clk   (clk),
      .rstN  (rstN),
      .load  (1'b0),
      .din   ('0),
      .shift (rx_shift),
      .clr   (rx_clr),
      .sin   (rx),
      .nxt   (rx_nxt),
      .sout  (rx_sout),
      .cnt   (rx_cnt)
   );

   ser_shift_reg #(.W(FB)) u_tx (
      .clk   (clk),
      .rstN  (rstN),
      .load  (tx_load),
      .din   (tx_frame),
      .shift (tx_shift),
      .clr   (1'b0),
      .sin   (1'b0),
      .nxt   (tx_nxt),
      .sout  (tx_sout),
      .cnt   (tx_cnt)
   );

   assign len_val  = rx_nxt[LEN_WIDTH-1:0];
   assign word_val = rx_nxt[WB-1:0];
   assign tx       = tx_act & tx_sout;

`ifdef SLAVE_PARITY_EN
   logic err_r;

   assign wdata    = word_val[WB-1:1];
   assign par_ok   = ~^word_val;
   assign tx_frame = {1'b1, mem_q, ^mem_q};
   assign err      = err_r;

   always_ff @(posedge clk) begin
      if (!rstN)
         err_r <= 1'b0;
      else if (start_acc)
         err_r <= 1'b0;
      else if (word_end && !par_ok)
         err_r <= 1'b1;
   end
`else
   assign wdata    = word_val;
   assign par_ok   = 1'b1;
   assign tx_frame = {1'b1, mem_q};
   assign err      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstN)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n     = state;
      rx_shift    = 1'b0;
      rx_clr      = 1'b0;
      tx_load     = 1'b0;
      tx_shift    = 1'b0;
      start_acc   = 1'b0;
      addr_end    = 1'b0;
      len_end     = 1'b0;
      word_end    = 1'b0;
      tx_word_end = 1'b0;
      unique case (state)
         IDLE: begin
            rx_clr = 1'b1;
            if (rx) begin
               start_acc = 1'b1;
               state_n   = CMD;
            end
         end
         CMD: begin
            rx_clr  = 1'b1;
            state_n = ADDR;
         end
         ADDR: begin
            rx_shift = 1'b1;
            if (rx_cnt == RCW'(ADDR_W - 1)) begin
               rx_clr   = 1'b1;
               addr_end = 1'b1;
               state_n  = LEN;
            end
         end
         LEN: begin
            rx_shift = 1'b1;
            if (rx_cnt == RCW'(LEN_WIDTH - 1)) begin
               rx_clr  = 1'b1;
               len_end = 1'b1;
               if (len_val == '0)
                  state_n = IDLE;
               else if (cmd_r == CMD_WRITE)
                  state_n = WDATA;
               else
                  state_n = RFETCH;
            end
         end
         WDATA: begin
            rx_shift = 1'b1;
            if (rx_cnt == RCW'(WB - 1)) begin
               rx_clr   = 1'b1;
               word_end = 1'b1;
               if (rem == LEN_WIDTH'(1))
                  state_n = IDLE;
            end
         end
         RFETCH: state_n = RSTART;
         RSTART: begin
            tx_load = 1'b1;
            state_n = RDATA;
         end
         RDATA: begin
            tx_shift = 1'b1;
            if (tx_cnt == TCW'(FB - 1)) begin
               tx_word_end = 1'b1;
               if (rem == LEN_WIDTH'(1))
                  state_n = IDLE;
               else
                  tx_load = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // cur always points at the next word to write or prefetch
   always_ff @(posedge clk) begin
      if (!rstN) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_wr      <= 1'b0;
         mem_address <= '0;
         mem_data    <= '0;
         cmd_r       <= 1'b0;
         base        <= '0;
         cur         <= '0;
         rem         <= '0;
         tx_act      <= 1'b0;
      end else begin
         done   <= 1'b0;
         mem_wr <= 1'b0;
         if (start_acc)
            busy <= 1'b1;
         if (state == CMD)
            cmd_r <= rx;
         if (addr_end)
            base <= rx_nxt[ADDR_W-1:0];
         if (len_end) begin
            rem <= len_val;
            if (len_val == '0) begin
               done <= 1'b1;
               busy <= 1'b0;
            end else if (cmd_r == CMD_WRITE) begin
               cur <= base;
            end else begin
               mem_address <= base;
               cur         <= inc(base);
            end
         end
         if (word_end) begin
            mem_wr      <= par_ok;
            mem_address <= cur;
            mem_data    <= wdata;
            cur         <= inc(cur);
            rem         <= rem - 1'b1;
            if (rem == LEN_WIDTH'(1)) begin
               done <= 1'b1;
               busy <= 1'b0;
            end
         end
         if (tx_load) begin
            tx_act      <= 1'b1;
            mem_address <= cur;
            cur         <= inc(cur);
         end
         if (tx_word_end) begin
            rem <= rem - 1'b1;
            if (rem == LEN_WIDTH'(1)) begin
               done   <= 1'b1;
               busy   <= 1'b0;
               tx_act <= 1'b0;
            end
         end
      end
   end

endmodule
